// File: rtl/addr_seq_key_if.sv
// Bus-side signal bundle for the address-sequence key unlock block.
// The master drives access qualifiers and the address nibble; the slave returns the response bit.
interface addr_seq_key_if #(
    parameter int NIB_W = 4
);
    logic             acc_stb;
    logic             sser_n;
    logic             ba13;
    logic             ba12;
    logic             br_w;
    logic [NIB_W-1:0] ba_nib;
    logic             sd_out;
    logic             sd_oe;

    modport master (
        output acc_stb, sser_n, ba13, ba12, br_w, ba_nib,
        input  sd_out, sd_oe
    );

    modport slave (
        input  acc_stb, sser_n, ba13, ba12, br_w, ba_nib,
        output sd_out, sd_oe
    );
endinterface

// File: rtl/addr_seq_key.sv
// Address-sequence unlock: a run of qualified reads whose address nibbles match a key
// unlocks an LFSR-driven response stream; a relock nibble or a read budget locks it again.
module addr_seq_key #(
    parameter int                         SEQ_LEN    = 4,
    parameter int                         NIB_W      = 4,
    parameter logic [SEQ_LEN*NIB_W-1:0]   KEY_SEQ    = 16'h8A92,
    parameter logic [NIB_W-1:0]           RELOCK_NIB = 4'hF,
    parameter int                         LFSR_W     = 6,
    parameter logic [LFSR_W-1:0]          LFSR_SEED  = 6'h2D,
    parameter int                         MAX_RD     = 0,
    parameter int                         MODE       = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    addr_seq_key_if.slave     bus,
    output logic              unlocked,
    output logic [3:0]        step
);

    localparam int              RD_W     = (MAX_RD > 0) ? $clog2(MAX_RD + 1) : 1;
    localparam logic [RD_W-1:0] RD_LIMIT = RD_W'(MAX_RD);
    localparam logic [3:0]      LAST     = 4'(SEQ_LEN - 1);

    typedef enum logic {LOCKED, UNLOCKED} state_t;

    state_t            state_q, state_d;
    logic [3:0]        step_q, step_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [RD_W-1:0]   rd_inc;
    logic [NIB_W-1:0]  key_nib;
    logic              qa;

    assign qa = bus.acc_stb & ~bus.sser_n & ~bus.ba13 & bus.ba12 & bus.br_w;

    assign bus.sd_oe  = qa;
    assign bus.sd_out = (state_q == UNLOCKED) ? lfsr_q[LFSR_W-1] : step_q[0];
    assign unlocked   = (state_q == UNLOCKED);
    assign step       = step_q;

    // Read counter saturates instead of wrapping so an unlimited budget never relocks.
    assign rd_inc = (rd_q == '1) ? rd_q : rd_q + RD_W'(1);

    always_comb begin
        key_nib = '0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (step_q == 4'(i)) key_nib = KEY_SEQ[i*NIB_W +: NIB_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOCKED;
            step_q  <= '0;
            lfsr_q  <= LFSR_SEED;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            lfsr_q  <= lfsr_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        lfsr_d  = lfsr_q;
        rd_d    = rd_q;
        if (qa) begin
            case (state_q)
                LOCKED: begin
                    if (bus.ba_nib == key_nib) begin
                        if (step_q == LAST) begin
                            state_d = UNLOCKED;
                            step_d  = '0;
                            lfsr_d  = LFSR_SEED;
                            rd_d    = '0;
                        end else begin
                            step_d = step_q + 4'd1;
                        end
                    end else begin
                        // MODE 1 lets a mismatching first-key nibble start a fresh attempt.
                        step_d = (MODE == 1 && bus.ba_nib == KEY_SEQ[NIB_W-1:0]) ? 4'd1 : 4'd0;
                    end
                end
                UNLOCKED: begin
                    if (bus.ba_nib == RELOCK_NIB) begin
                        state_d = LOCKED;
                        step_d  = '0;
                    end else begin
                        lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_W-1] ^ lfsr_q[LFSR_W-2]};
                        rd_d   = rd_inc;
                        if (MAX_RD > 0 && rd_inc == RD_LIMIT) begin
                            state_d = LOCKED;
                            step_d  = '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addr_seq_key.sv
// Bench for addr_seq_key: three instances (MODE 0, MODE 1, MAX_RD=3) see identical traffic
// and are compared against a per-instance behavioural model.
module tb_addr_seq_key;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       acc_stb, sser_n, ba13, ba12, br_w;
    logic [3:0] ba_nib;

    always #5 clk = ~clk;

    addr_seq_key_if #(.NIB_W(4)) bus0 ();
    addr_seq_key_if #(.NIB_W(4)) bus1 ();
    addr_seq_key_if #(.NIB_W(4)) bus2 ();

    assign bus0.acc_stb = acc_stb;  assign bus1.acc_stb = acc_stb;  assign bus2.acc_stb = acc_stb;
    assign bus0.sser_n  = sser_n;   assign bus1.sser_n  = sser_n;   assign bus2.sser_n  = sser_n;
    assign bus0.ba13    = ba13;     assign bus1.ba13    = ba13;     assign bus2.ba13    = ba13;
    assign bus0.ba12    = ba12;     assign bus1.ba12    = ba12;     assign bus2.ba12    = ba12;
    assign bus0.br_w    = br_w;     assign bus1.br_w    = br_w;     assign bus2.br_w    = br_w;
    assign bus0.ba_nib  = ba_nib;   assign bus1.ba_nib  = ba_nib;   assign bus2.ba_nib  = ba_nib;

    logic       unl_w[3];
    logic [3:0] step_w[3];
    logic       sdo_w[3];
    logic       sdoe_w[3];

    assign sdo_w[0] = bus0.sd_out;  assign sdoe_w[0] = bus0.sd_oe;
    assign sdo_w[1] = bus1.sd_out;  assign sdoe_w[1] = bus1.sd_oe;
    assign sdo_w[2] = bus2.sd_out;  assign sdoe_w[2] = bus2.sd_oe;

    addr_seq_key #(.MODE(0), .MAX_RD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .unlocked(unl_w[0]), .step(step_w[0]));
    addr_seq_key #(.MODE(1), .MAX_RD(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .unlocked(unl_w[1]), .step(step_w[1]));
    addr_seq_key #(.MODE(0), .MAX_RD(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave), .unlocked(unl_w[2]), .step(step_w[2]));

    // Reference model: one record per instance, updated only by qualified reads.
    int key[4]     = '{2, 9, 10, 8};
    int mode_p[3]  = '{0, 1, 0};
    int maxrd_p[3] = '{0, 0, 3};
    bit m_unl[3];
    int m_step[3];
    int m_lfsr[3];
    int m_rd[3];

    int   errors = 0;
    int   checks = 0;
    logic obs_oe[3];
    logic obs_out[3];
    bit   exp_oe;
    bit   exp_out[3];

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_unl[i] = 0; m_step[i] = 0; m_lfsr[i] = 'h2D; m_rd[i] = 0;
        end
    endfunction

    function automatic void model_access(int i, int nib);
        if (!m_unl[i]) begin
            if (nib == key[m_step[i]]) begin
                if (m_step[i] == 3) begin
                    m_unl[i] = 1; m_step[i] = 0; m_lfsr[i] = 'h2D; m_rd[i] = 0;
                end else begin
                    m_step[i] = m_step[i] + 1;
                end
            end else begin
                m_step[i] = (mode_p[i] == 1 && nib == key[0]) ? 1 : 0;
            end
        end else if (nib == 15) begin
            m_unl[i] = 0; m_step[i] = 0;
        end else begin
            m_lfsr[i] = ((m_lfsr[i] * 2) + (((m_lfsr[i] / 32) + (m_lfsr[i] / 16)) % 2)) % 64;
            m_rd[i]   = m_rd[i] + 1;
            if (maxrd_p[i] > 0 && m_rd[i] >= maxrd_p[i]) begin
                m_unl[i] = 0; m_step[i] = 0;
            end
        end
    endfunction

    // One bus cycle: drive at negedge, sample the combinational response, clock, update model.
    task automatic access(input int nib, input bit stb, input bit sn, input bit b13,
                          input bit b12, input bit rw);
        @(negedge clk);
        acc_stb = stb; sser_n = sn; ba13 = b13; ba12 = b12; br_w = rw; ba_nib = 4'(nib);
        #1;
        exp_oe = stb && !sn && !b13 && b12 && rw;
        for (int i = 0; i < 3; i++) begin
            obs_oe[i]  = sdoe_w[i];
            obs_out[i] = sdo_w[i];
            exp_out[i] = m_unl[i] ? bit'((m_lfsr[i] / 32) % 2) : bit'(m_step[i] % 2);
        end
        @(posedge clk);
        #1;
        if (exp_oe) for (int i = 0; i < 3; i++) model_access(i, nib);
        acc_stb = 1'b0;
    endtask

    task automatic read(input int nib);
        access(nib, 1, 0, 0, 1, 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b1; acc_stb = 0; sser_n = 1; ba13 = 0; ba12 = 0; br_w = 0; ba_nib = 0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (unl_w[i] !== 1'b0) begin errors++; $display("[TB] FAIL reset.unlocked inst=%0d got=%b exp=0", i, unl_w[i]); end
            checks++; if (step_w[i] !== 4'd0) begin errors++; $display("[TB] FAIL reset.step inst=%0d got=%0d exp=0", i, step_w[i]); end
            checks++; if (sdoe_w[i] !== 1'b0) begin errors++; $display("[TB] FAIL reset.sd_oe_idle inst=%0d got=%b exp=0", i, sdoe_w[i]); end
        end
        acc_stb = 1; sser_n = 0; ba12 = 1; br_w = 1; ba_nib = 4'd2;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (sdoe_w[i] !== 1'b1) begin errors++; $display("[TB] FAIL reset.sd_oe_qa inst=%0d got=%b exp=1", i, sdoe_w[i]); end
            checks++; if (sdo_w[i] !== 1'b0) begin errors++; $display("[TB] FAIL reset.sd_out inst=%0d got=%b exp=0", i, sdo_w[i]); end
            checks++; if (step_w[i] !== 4'd0) begin errors++; $display("[TB] FAIL reset.step_held inst=%0d got=%0d exp=0", i, step_w[i]); end
        end
        acc_stb = 0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_unlock();
        int nibs[4] = '{2, 9, 10, 8};
        int sd_exp[4] = '{0, 1, 0, 1};
        for (int k = 0; k < 4; k++) begin
            read(nibs[k]);
            checks++; if (obs_out[0] !== 1'(sd_exp[k])) begin errors++; $display("[TB] FAIL unlock.sd_seq k=%0d got=%b exp=%0d", k, obs_out[0], sd_exp[k]); end
            for (int i = 0; i < 3; i++) begin
                checks++; if (obs_oe[i] !== exp_oe) begin errors++; $display("[TB] FAIL unlock.sd_oe inst=%0d got=%b exp=%b", i, obs_oe[i], exp_oe); end
                checks++; if (obs_out[i] !== exp_out[i]) begin errors++; $display("[TB] FAIL unlock.sd_out inst=%0d got=%b exp=%b", i, obs_out[i], exp_out[i]); end
                checks++; if (unl_w[i] !== m_unl[i]) begin errors++; $display("[TB] FAIL unlock.unlocked inst=%0d got=%b exp=%b", i, unl_w[i], m_unl[i]); end
                checks++; if (step_w[i] !== 4'(m_step[i])) begin errors++; $display("[TB] FAIL unlock.step inst=%0d got=%0d exp=%0d", i, step_w[i], m_step[i]); end
            end
        end
        checks++; if (unl_w[0] !== 1'b1) begin errors++; $display("[TB] FAIL unlock.final got=%b exp=1", unl_w[0]); end
    endtask

    task automatic test_lfsr();
        int sd_exp[6] = '{1, 0, 1, 1, 0, 1};
        for (int k = 0; k < 6; k++) begin
            read(0);
            checks++; if (obs_out[0] !== 1'(sd_exp[k])) begin errors++; $display("[TB] FAIL lfsr.sd_seq k=%0d got=%b exp=%0d", k, obs_out[0], sd_exp[k]); end
            for (int i = 0; i < 3; i++) begin
                checks++; if (obs_out[i] !== exp_out[i]) begin errors++; $display("[TB] FAIL lfsr.sd_out inst=%0d got=%b exp=%b", i, obs_out[i], exp_out[i]); end
                checks++; if (unl_w[i] !== m_unl[i]) begin errors++; $display("[TB] FAIL lfsr.unlocked inst=%0d got=%b exp=%b", i, unl_w[i], m_unl[i]); end
            end
        end
    endtask

    task automatic test_relock();
        pulse_reset();
        read(2); read(9); read(10); read(8);
        access(15, 1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (obs_oe[i] !== 1'b0) begin errors++; $display("[TB] FAIL relock.write_oe inst=%0d got=%b exp=0", i, obs_oe[i]); end
            checks++; if (unl_w[i] !== m_unl[i]) begin errors++; $display("[TB] FAIL relock.write_hold inst=%0d got=%b exp=%b", i, unl_w[i], m_unl[i]); end
        end
        read(15);
        for (int i = 0; i < 3; i++) begin
            checks++; if (unl_w[i] !== 1'b0) begin errors++; $display("[TB] FAIL relock.unlocked inst=%0d got=%b exp=0", i, unl_w[i]); end
            checks++; if (step_w[i] !== 4'd0) begin errors++; $display("[TB] FAIL relock.step inst=%0d got=%0d exp=0", i, step_w[i]); end
        end
    endtask

    task automatic test_mode();
        int nibs[6] = '{2, 9, 2, 9, 10, 8};
        pulse_reset();
        for (int k = 0; k < 6; k++) begin
            read(nibs[k]);
            for (int i = 0; i < 3; i++) begin
                checks++; if (step_w[i] !== 4'(m_step[i])) begin errors++; $display("[TB] FAIL mode.step inst=%0d got=%0d exp=%0d", i, step_w[i], m_step[i]); end
            end
        end
        checks++; if (unl_w[0] !== 1'b0) begin errors++; $display("[TB] FAIL mode.m0_locked got=%b exp=0", unl_w[0]); end
        checks++; if (unl_w[1] !== 1'b1) begin errors++; $display("[TB] FAIL mode.m1_unlocked got=%b exp=1", unl_w[1]); end
    endtask

    task automatic test_max_rd();
        pulse_reset();
        read(2); read(9); read(10); read(8);
        for (int k = 0; k < 4; k++) begin
            read(3);
            checks++; if (obs_out[2] !== exp_out[2]) begin errors++; $display("[TB] FAIL max_rd.sd_out k=%0d got=%b exp=%b", k, obs_out[2], exp_out[2]); end
            checks++; if (unl_w[2] !== m_unl[2]) begin errors++; $display("[TB] FAIL max_rd.unlocked k=%0d got=%b exp=%b", k, unl_w[2], m_unl[2]); end
            checks++; if (unl_w[0] !== 1'b1) begin errors++; $display("[TB] FAIL max_rd.unlimited k=%0d got=%b exp=1", k, unl_w[0]); end
        end
        checks++; if (obs_out[2] !== 1'b0) begin errors++; $display("[TB] FAIL max_rd.fourth got=%b exp=0", obs_out[2]); end
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        read(2); read(9);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (step_w[i] !== 4'd0) begin errors++; $display("[TB] FAIL reset_mid.step inst=%0d got=%0d exp=0", i, step_w[i]); end
        end
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        read(10); read(8);
        for (int i = 0; i < 3; i++) begin
            checks++; if (unl_w[i] !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid.locked inst=%0d got=%b exp=0", i, unl_w[i]); end
        end
    endtask

    task automatic test_random();
        int sel, nib;
        bit sn, b13, b12, rw;
        pulse_reset();
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            nib = (sel < 6) ? key[$urandom_range(0, 3)] : (sel < 7) ? 15 : $urandom_range(0, 15);
            sn = 0; b13 = 0; b12 = 1; rw = 1;
            case ($urandom_range(0, 7))
                0: sn = 1;
                1: b13 = 1;
                2: b12 = 0;
                3: rw = 0;
                default: ;
            endcase
            if ($urandom_range(0, 99) == 0) pulse_reset();
            access(nib, $urandom_range(0, 5) != 0, sn, b13, b12, rw);
            for (int i = 0; i < 3; i++) begin
                checks++; if (obs_oe[i] !== exp_oe) begin errors++; $display("[TB] FAIL random.sd_oe n=%0d inst=%0d got=%b exp=%b", n, i, obs_oe[i], exp_oe); end
                if (exp_oe) begin
                    checks++; if (obs_out[i] !== exp_out[i]) begin errors++; $display("[TB] FAIL random.sd_out n=%0d inst=%0d got=%b exp=%b", n, i, obs_out[i], exp_out[i]); end
                end
                checks++; if (unl_w[i] !== m_unl[i]) begin errors++; $display("[TB] FAIL random.unlocked n=%0d inst=%0d got=%b exp=%b", n, i, unl_w[i], m_unl[i]); end
                checks++; if (step_w[i] !== 4'(m_step[i])) begin errors++; $display("[TB] FAIL random.step n=%0d inst=%0d got=%0d exp=%0d", n, i, step_w[i], m_step[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_lfsr();
        test_relock();
        test_mode();
        test_max_rd();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
